// File: rtl/jp_responder.sv
// jp_responder: NES joypad emulator answering the console's latch/clk strobes.
// Ports: clk_in/rst_in, jp_latch_in/jp_clk_in (async), buttons_in/btn_wr_in,
//        jp_data_out (pin level), bit_cnt_out, latch_cnt_out.
module jp_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        jp_latch_in,
  input  logic        jp_clk_in,
  input  logic [7:0]  buttons_in,
  input  logic        btn_wr_in,
  output logic        jp_data_out,
  output logic [3:0]  bit_cnt_out,
  output logic [15:0] latch_cnt_out
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] FC_LAST = CW'(FILTER_CYCLES - 1);

  localparam int LATCH = 0;
  localparam int SCLK  = 1;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_rise;

  assign w_raw = {jp_clk_in, jp_latch_in};

  // Per strobe: synchronizer, then a level filter that only flips after
  // the synchronized level has disagreed for FILTER_CYCLES cycles in a row.
  genvar g;
  for (g = 0; g < 2; g++) begin : g_cond
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_fcnt;
    logic                   r_filt;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_sync <= '0;
        r_fcnt <= '0;
        r_filt <= 1'b0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        r_prev <= r_filt;
        if (w_sync == r_filt) begin
          r_fcnt <= '0;
        end else if (r_fcnt == FC_LAST) begin
          r_filt <= w_sync;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + CW'(1);
        end
      end
    end

    assign w_filt[g] = r_filt;
    assign w_rise[g] = r_filt & ~r_prev;
  end

  logic [7:0]  r_btn;
  logic [7:0]  r_sr;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_latch_cnt;

  // r_sr holds pin levels (inverted buttons). Latch level has priority
  // over clk edges; zeros shift in so over-reads return a low pin.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_btn       <= 8'h00;
      r_sr        <= 8'hFF;
      r_bit_cnt   <= 4'd0;
      r_latch_cnt <= 16'd0;
    end else begin
      if (btn_wr_in) begin
        r_btn <= buttons_in;
      end
      if (w_rise[LATCH]) begin
        r_latch_cnt <= r_latch_cnt + 16'd1;
      end
      if (w_filt[LATCH]) begin
        r_sr      <= ~r_btn;
        r_bit_cnt <= 4'd0;
      end else if (w_rise[SCLK]) begin
        r_sr <= {1'b0, r_sr[7:1]};
        if (r_bit_cnt != 4'd8) begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  assign jp_data_out   = r_sr[0];
  assign bit_cnt_out   = r_bit_cnt;
  assign latch_cnt_out = r_latch_cnt;

endmodule

// File: tb/tb_jp_responder.sv
// tb_jp_responder: directed checks for jp_responder.
// Drives strobes/buttons, checks pin, bit count and frame count.
module tb_jp_responder;

  logic        clk_in;
  logic        rst_in;
  logic        jp_latch_in;
  logic        jp_clk_in;
  logic [7:0]  buttons_in;
  logic        btn_wr_in;
  logic        jp_data_out;
  logic [3:0]  bit_cnt_out;
  logic [15:0] latch_cnt_out;

  int total;
  int fails;

  jp_responder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .jp_latch_in   (jp_latch_in),
    .jp_clk_in     (jp_clk_in),
    .buttons_in    (buttons_in),
    .btn_wr_in     (btn_wr_in),
    .jp_data_out   (jp_data_out),
    .bit_cnt_out   (bit_cnt_out),
    .latch_cnt_out (latch_cnt_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic latch_pulse();
    jp_latch_in = 1'b1;
    tick(12);
    jp_latch_in = 1'b0;
    tick(12);
  endtask

  task automatic clk_pulse();
    jp_clk_in = 1'b1;
    tick(12);
    jp_clk_in = 1'b0;
    tick(12);
  endtask

  task automatic write_btn(input logic [7:0] v);
    buttons_in = v;
    btn_wr_in  = 1'b1;
    tick(1);
    btn_wr_in  = 1'b0;
  endtask

  logic [7:0] basic_pins;

  initial begin
    total       = 0;
    fails       = 0;
    rst_in      = 1'b1;
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b0;
    buttons_in  = 8'h00;
    btn_wr_in   = 1'b0;
    basic_pins  = 8'b1111_0110;

    tick(3);
    chk("rst_pin", 16'(jp_data_out), 16'h1);
    chk("rst_bitcnt", 16'(bit_cnt_out), 16'h0);
    chk("rst_latchcnt", latch_cnt_out, 16'h0);
    rst_in = 1'b0;
    tick(3);

    // basic read, A+Start
    write_btn(8'h09);
    tick(2);
    latch_pulse();
    chk("basic_pin0", 16'(jp_data_out), 16'h0);
    chk("basic_cnt0", 16'(bit_cnt_out), 16'h0);
    chk("basic_frames", latch_cnt_out, 16'h1);
    for (int k = 1; k <= 8; k++) begin
      clk_pulse();
      chk($sformatf("basic_pin%0d", k), 16'(jp_data_out),
          (k < 8) ? 16'(basic_pins[k]) : 16'h0);
      chk($sformatf("basic_cnt%0d", k), 16'(bit_cnt_out), 16'(k));
    end

    // over-read
    for (int k = 0; k < 4; k++) begin
      clk_pulse();
      chk("over_pin", 16'(jp_data_out), 16'h0);
      chk("over_cnt", 16'(bit_cnt_out), 16'h8);
    end
    latch_pulse();
    chk("relatch_pin", 16'(jp_data_out), 16'h0);
    chk("relatch_cnt", 16'(bit_cnt_out), 16'h0);
    chk("relatch_frames", latch_cnt_out, 16'h2);

    // glitch rejection
    jp_latch_in = 1'b1;
    tick(2);
    jp_latch_in = 1'b0;
    tick(20);
    chk("glitch_l_frames", latch_cnt_out, 16'h2);
    jp_clk_in = 1'b1;
    tick(2);
    jp_clk_in = 1'b0;
    tick(20);
    chk("glitch_c_cnt", 16'(bit_cnt_out), 16'h0);
    chk("glitch_c_pin", 16'(jp_data_out), 16'h0);

    // 4-cycle clk pulse accepted, latency 7
    jp_clk_in = 1'b1;
    tick(4);
    jp_clk_in = 1'b0;
    tick(2);
    chk("lat6_cnt", 16'(bit_cnt_out), 16'h0);
    chk("lat6_pin", 16'(jp_data_out), 16'h0);
    tick(1);
    chk("lat7_cnt", 16'(bit_cnt_out), 16'h1);
    chk("lat7_pin", 16'(jp_data_out), 16'h1);
    tick(10);

    // clk pulses while latch high are ignored
    jp_latch_in = 1'b1;
    tick(10);
    for (int k = 0; k < 3; k++) begin
      jp_clk_in = 1'b1;
      tick(8);
      jp_clk_in = 1'b0;
      tick(8);
    end
    jp_latch_in = 1'b0;
    tick(12);
    chk("cdl_pin", 16'(jp_data_out), 16'h0);
    chk("cdl_cnt", 16'(bit_cnt_out), 16'h0);
    chk("cdl_frames", latch_cnt_out, 16'h3);

    // button write while latched
    jp_latch_in = 1'b1;
    tick(10);
    write_btn(8'h80);
    chk("wr_same_cycle", 16'(jp_data_out), 16'h0);
    tick(1);
    chk("wr_latched_pin", 16'(jp_data_out), 16'h1);
    chk("wr_frames", latch_cnt_out, 16'h4);
    jp_latch_in = 1'b0;
    tick(12);
    clk_pulse();
    clk_pulse();
    chk("mid_pin2", 16'(jp_data_out), 16'h1);
    write_btn(8'hFF);
    tick(2);
    clk_pulse();
    chk("mid_pin3", 16'(jp_data_out), 16'h1);
    for (int k = 0; k < 4; k++) clk_pulse();
    chk("mid_pin7", 16'(jp_data_out), 16'h0);
    chk("mid_cnt7", 16'(bit_cnt_out), 16'h7);

    // reset mid-frame
    latch_pulse();
    chk("allp_pin0", 16'(jp_data_out), 16'h0);
    chk("allp_frames", latch_cnt_out, 16'h5);
    for (int k = 0; k < 3; k++) clk_pulse();
    chk("allp_cnt3", 16'(bit_cnt_out), 16'h3);
    rst_in = 1'b1;
    #2;
    chk("arst_pin", 16'(jp_data_out), 16'h1);
    chk("arst_cnt", 16'(bit_cnt_out), 16'h0);
    chk("arst_frames", latch_cnt_out, 16'h0);
    tick(2);
    rst_in = 1'b0;
    tick(2);
    latch_pulse();
    chk("post_frames", latch_cnt_out, 16'h1);
    chk("post_pin0", 16'(jp_data_out), 16'h1);
    for (int k = 1; k <= 8; k++) begin
      clk_pulse();
      chk($sformatf("post_pin%0d", k), 16'(jp_data_out),
          (k < 8) ? 16'h1 : 16'h0);
    end

    // frame counter wrap, starting near the top
    force dut.r_latch_cnt = 16'hFFFE;
    #1;
    release dut.r_latch_cnt;
    tick(1);
    chk("wrap_preset", latch_cnt_out, 16'hFFFE);
    latch_pulse();
    chk("wrap_ffff", latch_cnt_out, 16'hFFFF);
    latch_pulse();
    chk("wrap_zero", latch_cnt_out, 16'h0000);
    chk("wrap_pin", 16'(jp_data_out), 16'h1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/jp_responder.md
# jp_responder

Controller-side responder for the NES joypad serial protocol. It emulates a standard NES controller (CD4021 parallel-in/serial-out behaviour) driven by the console's `jp_latch`/`jp_clk` strobes and returns button bits on the data line. The button state is supplied by a host-side block such as the HCI. The block is used for test rigs and for controller emulation without a physical pad. Its strobe inputs are treated as asynchronous pins.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on each strobe input; must be ≥ 2.
- `FILTER_CYCLES`, 4: consecutive stable cycles required before a strobe level is accepted; must be ≥ 1.

Ports:
- `clk_in` input 1: system clock (50 MHz).
- `rst_in` input 1: asynchronous active-high reset.
- `jp_latch_in` input 1: latch strobe from the console, asynchronous.
- `jp_clk_in` input 1: shift clock from the console, asynchronous.
- `buttons_in` input 8: pressed state, active-high. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- `btn_wr_in` input 1: one-cycle strobe that captures `buttons_in` into the button register.
- `jp_data_out` output 1: data pin level, registered. Low means pressed, or past the 8th bit.
- `bit_cnt_out` output 4: bits shifted since the last latch, saturating at 8.
- `latch_cnt_out` output 16: count of accepted latch rising edges (frames), wraps 0xFFFF→0.

## Operation
- **Input conditioning (per strobe):**
  - SYNC_STAGES-flop synchronizer, then a glitch filter.
  - The filtered level changes only after the synchronized level has differed from it for FILTER_CYCLES consecutive cycles.
  - The filter counter clears on any cycle where the synchronized level equals the filtered level.
- **Edge detection:** rise/fall pulses are derived from the filtered levels (previous vs current); each pulse is one cycle wide.
- **Button register `btn_q[7:0]`:** loaded from `buttons_in` on `btn_wr_in`. Otherwise it holds.
- **Shift register `sr[7:0]` holds pin levels:**
  - While filtered latch is high, every cycle: `sr <= ~btn_q`, `bit_cnt <= 0`.
  - While latch is low, on filtered clk rising edge: `sr <= {1'b0, sr[7:1]}`, `bit_cnt <= min(bit_cnt+1, 8)`.
  - Clk edges while latch is high are ignored, because the load has priority.
- **Output:** `jp_data_out = sr[0]`.
  - After 8 shifts the pin reads 0, matching an official pad where the CPU sees 1s.
- **Frame counter:** `latch_cnt` increments on each filtered latch rising edge.
- **Simultaneous events:**
  - `btn_wr_in` in the same cycle as a latch load: `sr` loads the old `btn_q` that cycle and the new value from the next cycle on, if latch is still high.
  - A `btn_wr_in` while latch is low does not affect bits already loaded into `sr`.
- **Reset (asynchronous, any time, including mid-frame):**
  - `btn_q`=0, `sr`=8'hFF, `jp_data_out`=1, `bit_cnt_out`=0, `latch_cnt_out`=0.
  - Synchronizers, filtered levels and edge history reset to 0.
  - A strobe held high through reset release is seen as a rising edge after filtering.

## Timing
- Pin edge to `jp_data_out` change: SYNC_STAGES + FILTER_CYCLES + 1 clk_in edges, which is 7 with the defaults. The same latency applies to `bit_cnt_out` and `latch_cnt_out`.
- Minimum accepted strobe pulse (high or low) is FILTER_CYCLES cycles. Shorter pulses are discarded entirely.
- `btn_wr_in` → `btn_q` in 1 cycle; `btn_q` → `sr` on the next cycle while latch is high.
- Data setup for the console: `jp_data_out` is stable from 7 cycles after a clk rise until 7 cycles after the next clk rise. This is far below the ~6 µs NES strobe period.
- No back-pressure or handshake toward the console; the block is a pure responder.

## Test plan
- **Basic read:** write `buttons_in`=8'h09 (A+Start), pulse latch 12 cycles, then 8 clk pulses of 12 cycles each.
  - Pin sequence 0,1,1,0,1,1,1,1 (A first).
  - `bit_cnt_out` steps 0→8.
  - `latch_cnt_out`=1.
- **Over-read:** after the basic read, 4 extra clk pulses.
  - `jp_data_out`=0 each time; `bit_cnt_out` stays 8.
  - A new latch restores bit A and sets count 0.
- **Glitch rejection:** 2-cycle pulses on latch and on clk.
  - No change to `sr`, `bit_cnt_out` or `latch_cnt_out`.
  - A 4-cycle pulse is accepted with latency 7.
- **Clk during latch:** 3 clk pulses while latch is high, then latch falls.
  - The first bit read is still A; `bit_cnt_out`=0.
- **Button update:**
  - `btn_wr_in` with 8'h80 while latch is high → pin reflects the new A bit (1) within 2 cycles.
  - The same write mid-shift does not alter the remaining bits of the current frame.
- **Reset mid-frame:** assert `rst_in` after 3 shifts.
  - Immediately `jp_data_out`=1, `bit_cnt_out`=0, `latch_cnt_out`=0.
  - After reset, the next latch loads 8'hFF (btn_q cleared), so the pin reads 1 for all 8 bits.
  - Also run 65536 latches → `latch_cnt_out` wraps to 0.
